// File: rtl/reg_context_sequencer_if.sv
// Memory-side request port of the register context sequencer.
// One outstanding request: accepted on req && ready, read data returns on rvalid.
interface reg_context_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/reg_context_sequencer.sv
// Saves or restores register-file entries FIRST_REG..LAST_REG to/from memory
// for context switch and trap entry, one register per memory request.
module reg_context_sequencer #(
    parameter int unsigned FIRST_REG   = 1,
    parameter int unsigned LAST_REG    = 31,
    parameter int unsigned ADDR_STRIDE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_read_addr,
    input  logic [31:0] rf_read_data,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic        rf_write_en,
    reg_context_sequencer_if.master mem
);
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SAVE_REQ  = 3'd1,
        REST_REQ  = 3'd2,
        REST_WAIT = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t              state, state_nx;
    logic [IDX_W-1:0]    idx, idx_nx;
    logic [DATA_W-1:0]   addr, addr_nx;
    logic                wr_en_nx;
    logic [IDX_W-1:0]    wr_addr_nx;
    logic [DATA_W-1:0]   wr_data_nx;
    logic                req_q, we_q;
    logic                last;

    assign last = (idx == IDX_W'(LAST_REG));

    // Next-state and datapath; in restore the write-back cycle stays in REST_WAIT
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        addr_nx    = addr;
        wr_en_nx   = 1'b0;
        wr_addr_nx = rf_write_addr;
        wr_data_nx = rf_write_data;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_nx   = IDX_W'(FIRST_REG);
                    addr_nx  = base_addr;
                    state_nx = mode ? REST_REQ : SAVE_REQ;
                end
            end
            SAVE_REQ: begin
                if (mem.mem_ready) begin
                    if (last) begin
                        state_nx = FINISH;
                    end else begin
                        idx_nx  = idx + IDX_W'(1);
                        addr_nx = addr + DATA_W'(ADDR_STRIDE);
                    end
                end
            end
            REST_REQ: begin
                if (mem.mem_ready) state_nx = REST_WAIT;
            end
            REST_WAIT: begin
                if (rf_write_en) begin
                    if (last) begin
                        state_nx = FINISH;
                    end else begin
                        idx_nx   = idx + IDX_W'(1);
                        addr_nx  = addr + DATA_W'(ADDR_STRIDE);
                        state_nx = REST_REQ;
                    end
                end else if (mem.mem_rvalid) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = idx;
                    wr_data_nx = mem.mem_rdata;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            addr          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            addr          <= addr_nx;
            busy          <= (state_nx != IDLE);
            done          <= (state_nx == FINISH);
            req_q         <= (state_nx == SAVE_REQ) || (state_nx == REST_REQ);
            we_q          <= (state_nx == SAVE_REQ);
            rf_write_en   <= wr_en_nx;
            rf_write_addr <= wr_addr_nx;
            rf_write_data <= wr_data_nx;
        end
    end

    // Save data is passed straight from the register-file read port
    assign rf_read_addr  = idx;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = (state == SAVE_REQ) ? rf_read_data : '0;
endmodule
